// File: rtl/poly_sched_if.sv
// Requester-side bus of the shared polynomial evaluator.
// Two requesters, each with req/coef in and ack/done out.
interface poly_sched_if;
  logic        req0;
  logic        req1;
  logic [31:0] coef0;
  logic [31:0] coef1;
  logic        ack0;
  logic        ack1;
  logic        done0;
  logic        done1;
  logic [7:0]  result;
  logic        busy;

  modport master (
    output req0, req1, coef0, coef1,
    input  ack0, ack1, done0, done1, result, busy
  );

  modport slave (
    input  req0, req1, coef0, coef1,
    output ack0, ack1, done0, done1, result, busy
  );
endinterface

// File: rtl/poly_sched.sv
// Two-requester scheduler for a*x^2+b*x+c on one shared 8-bit ALU.
// POLY_SCHED_FIXED_PRIO_EN: req0 always wins ties (no last_grant).
module poly_sched (
  input logic        clk,
  input logic        reset,
  poly_sched_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL1,
    S_ADD1,
    S_MUL2,
    S_ADD2,
    S_DONE
  } state_t;

  state_t      state;
  logic [7:0]  a, b, c, x;
  logic [7:0]  acc;
  logic [7:0]  result;
  logic        owner;
  logic        ack0, ack1;
  logic        done0, done1;
  logic        busy;
`ifndef POLY_SCHED_FIXED_PRIO_EN
  logic        last_grant;
`endif

  logic        any_req;
  logic        win;
  logic [31:0] sel_coef;
  logic [7:0]  op_a, op_b;
  logic        op_mul;
  logic [15:0] prod;
  logic [7:0]  alu_y;

  // Pick a winner among the active requesters.
  always_comb begin
    any_req = bus.req0 | bus.req1;
`ifdef POLY_SCHED_FIXED_PRIO_EN
    win = ~bus.req0;
`else
    if (bus.req0 && bus.req1)
      win = ~last_grant;
    else
      win = ~bus.req0;
`endif
    sel_coef = win ? bus.coef1 : bus.coef0;
  end

  // Operand steering for the single shared add/multiply unit.
  always_comb begin
    op_a   = acc;
    op_b   = b;
    op_mul = 1'b0;
    case (state)
      S_MUL1: begin
        op_a   = a;
        op_b   = x;
        op_mul = 1'b1;
      end
      S_ADD1: op_b = b;
      S_MUL2: begin
        op_b   = x;
        op_mul = 1'b1;
      end
      S_ADD2: op_b = c;
      default: op_b = b;
    endcase
  end

  assign prod  = {8'd0, op_a} * {8'd0, op_b};
  assign alu_y = op_mul ? prod[7:0] : op_a + op_b;

  // Sequencer: capture, four ALU steps, done, back to idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= S_IDLE;
      a      <= '0;
      b      <= '0;
      c      <= '0;
      x      <= '0;
      acc    <= '0;
      result <= '0;
      owner  <= 1'b0;
      ack0   <= 1'b0;
      ack1   <= 1'b0;
      done0  <= 1'b0;
      done1  <= 1'b0;
      busy   <= 1'b0;
`ifndef POLY_SCHED_FIXED_PRIO_EN
      last_grant <= 1'b1;
`endif
    end else begin
      ack0  <= 1'b0;
      ack1  <= 1'b0;
      done0 <= 1'b0;
      done1 <= 1'b0;
      case (state)
        S_IDLE: begin
          if (any_req) begin
            {a, b, c, x} <= sel_coef;
            owner <= win;
            ack0  <= ~win;
            ack1  <= win;
            busy  <= 1'b1;
`ifndef POLY_SCHED_FIXED_PRIO_EN
            last_grant <= win;
`endif
            state <= S_MUL1;
          end
        end
        S_MUL1: begin
          acc   <= alu_y;
          state <= S_ADD1;
        end
        S_ADD1: begin
          acc   <= alu_y;
          state <= S_MUL2;
        end
        S_MUL2: begin
          acc   <= alu_y;
          state <= S_ADD2;
        end
        S_ADD2: begin
          result <= alu_y;
          done0  <= ~owner;
          done1  <= owner;
          state  <= S_DONE;
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.ack0   = ack0;
  assign bus.ack1   = ack1;
  assign bus.done0  = done0;
  assign bus.done1  = done1;
  assign bus.result = result;
  assign bus.busy   = busy;

endmodule

// File: tb/tb_poly_sched.sv
// Bench for poly_sched: transaction model plus directed scenarios
// and a randomized requester phase.
module tb_poly_sched;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  poly_sched_if bus ();

  poly_sched dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  bit chk_on   = 1'b0;

  // Model: cycles elapsed since capture (0 = idle), owner, value.
  int         m_phase  = 0;
  bit         m_owner  = 1'b0;
  bit         m_last   = 1'b1;
  logic [7:0] m_val    = '0;
  logic [7:0] m_result = '0;

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b expected=%b t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk8(input string nm, input logic [7:0] act,
                      input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%02h expected=%02h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic chkn(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] poly(input logic [31:0] k);
    int unsigned pa, pb, pc, px, v;
    pa = k[31:24];
    pb = k[23:16];
    pc = k[15:8];
    px = k[7:0];
    v  = pa * px * px + pb * px + pc;
    return v[7:0];
  endfunction

  // Transaction-level reference: arbitration and 6-cycle occupancy.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_phase  = 0;
      m_owner  = 1'b0;
      m_last   = 1'b1;
      m_result = '0;
    end else if (m_phase == 0) begin
      if (bus.req0 || bus.req1) begin
`ifdef POLY_SCHED_FIXED_PRIO_EN
        m_owner = !bus.req0;
`else
        if (bus.req0 && bus.req1)
          m_owner = !m_last;
        else
          m_owner = bus.req1;
`endif
        m_last  = m_owner;
        m_val   = poly(m_owner ? bus.coef1 : bus.coef0);
        m_phase = 1;
      end
    end else if (m_phase == 5) begin
      m_phase = 0;
    end else begin
      m_phase = m_phase + 1;
      if (m_phase == 5)
        m_result = m_val;
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_on && !reset) begin
      chk1("ack0",  bus.ack0,  m_phase == 1 && !m_owner);
      chk1("ack1",  bus.ack1,  m_phase == 1 && m_owner);
      chk1("done0", bus.done0, m_phase == 5 && !m_owner);
      chk1("done1", bus.done1, m_phase == 5 && m_owner);
      chk1("busy",  bus.busy,  m_phase != 0);
      chk8("result", bus.result, m_result);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic sig(input int s);
    case (s)
      0: return bus.ack0;
      1: return bus.ack1;
      2: return bus.done0;
      3: return bus.done1;
      default: return bus.ack0 | bus.ack1;
    endcase
  endfunction

  task automatic wait_for(input int s, output int n);
    n = -1;
    for (int i = 1; i <= 30; i++) begin
      step();
      if (sig(s)) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 20; i++) begin
      if (!bus.busy) break;
      step();
    end
    chk1("idle_reached", bus.busy, 1'b0);
  endtask

  task automatic set_req(input bit g, input logic [31:0] k);
    if (g) begin
      bus.coef1 = k;
      bus.req1  = 1'b1;
    end else begin
      bus.coef0 = k;
      bus.req0  = 1'b1;
    end
  endtask

  task automatic run_one(input bit g, input logic [31:0] k,
                         input logic [7:0] exp, input bit garble);
    int n;
    int extra;
    extra = 0;
    set_req(g, k);
    wait_for(g ? 1 : 0, n);
    chkn("ack_cycle", n, 1);
    if (g) bus.req1 = 1'b0;
    else   bus.req0 = 1'b0;
    if (garble) begin
      step();
      extra = 1;
      if (g) bus.coef1 = ~k;
      else   bus.coef0 = ~k;
    end
    wait_for(g ? 3 : 2, n);
    chkn("done_cycle", 1 + extra + n, 5);
    chk8("poly_result", bus.result, exp);
    step();
  endtask

  initial begin
    int n;
    int cnt;
    int lows;
    int sp;
    bus.req0  = 1'b0;
    bus.req1  = 1'b0;
    bus.coef0 = '0;
    bus.coef1 = '0;

    chk8("model_poly_a", poly(32'h01020304), 8'h1B);
    chk8("model_poly_b", poly(32'h10000004), 8'h00);
    chk8("model_poly_c", poly(32'h02030503), 8'h20);

    #1 reset = 1'b1;
    #3;
    chk8("reset_result", bus.result, 8'h00);
    chk1("reset_busy",  bus.busy,  1'b0);
    chk1("reset_ack0",  bus.ack0,  1'b0);
    chk1("reset_ack1",  bus.ack1,  1'b0);
    chk1("reset_done0", bus.done0, 1'b0);
    chk1("reset_done1", bus.done1, 1'b0);
    @(negedge clk);
    reset  = 1'b0;
    chk_on = 1'b1;
    step();

    run_one(1'b0, 32'h01020304, 8'h1B, 1'b0);
    run_one(1'b1, 32'h10000004, 8'h00, 1'b0);
    run_one(1'b1, 32'h02030503, 8'h20, 1'b0);
    run_one(1'b0, 32'h01020304, 8'h1B, 1'b1);

    // Abort in S_MUL2 with a prior nonzero result.
    set_req(1'b0, 32'h01020304);
    wait_for(0, n);
    chkn("abort_ack_cycle", n, 1);
    bus.req0 = 1'b0;
    step();
    step();
    #2 reset = 1'b1;
    #1;
    chk8("abort_result", bus.result, 8'h00);
    chk1("abort_busy",  bus.busy,  1'b0);
    chk1("abort_ack0",  bus.ack0,  1'b0);
    chk1("abort_done0", bus.done0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (bus.done0 || bus.done1) cnt++;
    end
    chkn("abort_no_done", cnt, 0);
    bus.coef0 = $urandom;
    bus.coef1 = $urandom;
    bus.req0  = 1'b1;
    bus.req1  = 1'b1;
    wait_for(4, n);
    chkn("tie_ack_cycle", n, 1);
    chk1("tie_after_reset_ack0", bus.ack0, 1'b1);
    bus.req0 = 1'b0;
    wait_for(1, n);
    chk1("second_grant_seen", n > 0, 1'b1);
    bus.req1 = 1'b0;
    wait_idle();

    // Both held from reset: grant order.
    reset = 1'b1;
    bus.coef0 = $urandom;
    bus.coef1 = $urandom;
    bus.req0  = 1'b1;
    bus.req1  = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      wait_for(4, n);
      chk1("grant_seen", n > 0, 1'b1);
`ifdef POLY_SCHED_FIXED_PRIO_EN
      chk1("grant_order", bus.ack1, 1'b0);
`else
      chk1("grant_order", bus.ack1, k[0]);
`endif
    end
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    wait_idle();

    // Back-to-back with req0 held.
    step();
    set_req(1'b0, $urandom);
    wait_for(0, n);
    chkn("b2b_first_ack", n, 1);
    for (int r = 0; r < 2; r++) begin
      lows = 0;
      sp   = -1;
      for (int i = 1; i <= 30; i++) begin
        step();
        if (!bus.busy) lows++;
        if (bus.ack0) begin
          sp = i;
          break;
        end
      end
      chkn("b2b_spacing", sp, 6);
      chkn("b2b_busy_low", lows, 1);
    end
    bus.req0 = 1'b0;
    wait_idle();

    // Randomized requesters.
    for (int i = 0; i < 2000; i++) begin
      step();
      if (bus.req0 && bus.ack0) begin
        if ($urandom_range(0, 1) == 0) bus.req0 = 1'b0;
        bus.coef0 = $urandom;
      end else if (!bus.req0) begin
        bus.coef0 = $urandom;
        if ($urandom_range(0, 3) == 0) bus.req0 = 1'b1;
      end
      if (bus.req1 && bus.ack1) begin
        if ($urandom_range(0, 1) == 0) bus.req1 = 1'b0;
        bus.coef1 = $urandom;
      end else if (!bus.req1) begin
        bus.coef1 = $urandom;
        if ($urandom_range(0, 3) == 0) bus.req1 = 1'b1;
      end
    end
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    step();
    wait_idle();
    repeat (3) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/poly_sched.md
POLY_SCHED -- requirements
Module: poly_sched

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, with ports clk and reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-004 req0, req1  input  1 each  requester g asks for one evaluation of a*x^2 + b*x + c.
REQ-005 coef0, coef1  input  32 each  operands {a[31:24], b[23:16], c[15:8], x[7:0]}, unsigned.
REQ-006 ack0, ack1  output  1 each  one-cycle pulse: requester g's operands were captured.
REQ-007 done0, done1  output  1 each  one-cycle pulse: result holds requester g's answer.
REQ-008 result  output  8  last computed polynomial value.
REQ-009 busy  output  1  high in every state except S_IDLE.

Function
REQ-010 The FSM SHALL have states S_IDLE, S_MUL1, S_ADD1, S_MUL2, S_ADD2 and S_DONE, in that order, with no stalls.
REQ-011 In S_IDLE with no request asserted, the block SHALL remain in S_IDLE.
REQ-012 In S_IDLE with any request asserted, the block SHALL do the following on the next clk edge: select a winner, latch the winner's coef into internal registers, record the owner, and enter S_MUL1.
REQ-013 S_MUL1 SHALL load acc <= a*x.
REQ-014 S_ADD1 SHALL load acc <= acc + b.
REQ-015 S_MUL2 SHALL load acc <= acc * x.
REQ-016 S_ADD2 SHALL load result <= acc + c.
REQ-017 The arithmetic SHALL use a single shared add/multiply ALU.
REQ-018 All arithmetic SHALL be 8-bit unsigned, truncated modulo 256, with no overflow flag.
REQ-019 ack_owner SHALL be high exactly during the S_MUL1 cycle; the other ack SHALL stay low.
REQ-020 done_owner SHALL be high exactly during the S_DONE cycle.
REQ-021 S_DONE SHALL always return to S_IDLE.
REQ-022 Latency from the capture edge to done SHALL be 5 cycles; minimum spacing between captures SHALL be 6 cycles.
REQ-023 result SHALL hold its value from the S_ADD2 edge until the next S_ADD2 edge.
REQ-024 Coefficients are sampled only at the capture edge; changes to coef afterwards SHALL NOT affect the computation in progress.
REQ-025 A requester SHALL hold req and coef stable until its ack.
REQ-026 A req still high when the block returns to S_IDLE SHALL be treated as a new request.
REQ-027 Requests arriving while busy SHALL be ignored until S_IDLE; they SHALL NOT be dropped if they are still held.
REQ-028 Arbitration SHALL be round-robin via a last_grant register: when both requesters are active, the requester not granted last wins.
REQ-029 After reset, last_grant SHALL be 1, so req0 wins the first tie.
REQ-030 With a single active requester, that requester SHALL win regardless of last_grant.

Reset
REQ-031 Asserting reset SHALL, without waiting for clk: set state to S_IDLE; clear acc, operand registers, result, owner, ack*, done* and busy to 0; and set last_grant to 1.
REQ-032 Reset mid-operation SHALL abort the evaluation; no done SHALL be emitted for the aborted request.
REQ-033 After reset deasserts, the first edge SHALL be treated as S_IDLE.

Configuration
REQ-034 When macro POLY_SCHED_FIXED_PRIO_EN is defined, arbitration SHALL be fixed priority: req0 always wins ties, and last_grant SHALL be absent or ignored.
REQ-035 When POLY_SCHED_FIXED_PRIO_EN is undefined, arbitration SHALL be round-robin per REQ-028 to REQ-030.

Verification
REQ-036 Single-request scenario: req0 with a=1, b=2, c=3, x=4 -> ack0 in the cycle after capture, done0 5 cycles after capture, result=0x1B, ack1/done1 never high.
REQ-037 Overflow scenario: req1 with a=16, b=0, c=0, x=4 -> result=0x00; req1 with a=2, b=3, c=5, x=3 -> result=0x20.
REQ-038 Simultaneous-request scenario: req0 and req1 held high from reset -> grant order 0,1,0,1; with POLY_SCHED_FIXED_PRIO_EN defined, only requester 0 is ever granted.
REQ-039 Mid-run operand change: coef0 changed during S_ADD1 -> result still reflects the captured operands (0x1B).
REQ-040 Reset during S_MUL2 -> all outputs 0 immediately, no done pulse, next request restarts with a req0 win on a tie.
REQ-041 Back-to-back scenario: req0 held continuously -> captures spaced exactly 6 cycles apart, busy low for exactly 1 cycle between evaluations.
